bin2seg_encoder: RTL and testbench
==================================

# bin2seg_encoder

Sequential binary-to-seven-segment encoder that produces the two-digit 14-bit segment word consumed by the display multiplexer stage. It accepts an 8-bit binary value on a start pulse and converts it to two BCD digits with a bit-serial double-dabble engine. It then encodes both digits into segment patterns and updates the packed output word atomically. Values outside 0..99 are flagged and shown as two dashes.

## Interface
- `LZB`, default 1: leading-zero blanking. When 1, a tens digit of 0 is shown blank (7'h00).
- `clk`, input, 1: sole clock; all state changes on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: conversion request; sampled only in IDLE.
- `value`, input, 8: binary value, latched on the accepted start.
- `busy`, output, 1: high whenever state is not IDLE.
- `done`, output, 1: one-cycle pulse when `both7seg` is updated.
- `overflow`, output, 1: latched with each result; 1 iff the latched value > 99.
- `both7seg`, output, 14: [13:7] tens pattern, [6:0] units pattern. Bit order within each pattern is {g,f,e,d,c,b,a}, active-high.

## Operation
- States are IDLE, CONV and ENC.
- IDLE:
  - On `start=1`: latch `value` into a shift register, clear the 12-bit BCD register, clear the shift counter, go to CONV.
  - On `start=0`: remain in IDLE.
- CONV, once per cycle:
  - Add 3 to each BCD nibble (units, tens, hundreds) that is ≥5.
  - Then shift {BCD, bin} left by 1.
  - Increment the counter. After the 8th shift, go to ENC.
- ENC, one cycle:
  - Compute `overflow` = (hundreds != 0) or (tens > 9). Tens cannot exceed 9 when hundreds is 0, but the check is explicit.
  - If overflow: `both7seg` = {7'h40, 7'h40} (two dashes).
  - Otherwise, units pattern is the digit code. Tens pattern is the digit code, or 7'h00 if `LZB`=1 and tens=0.
  - Register `both7seg`, `overflow` and `done`=1 on the same edge. Go to IDLE.
- Digit codes:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - Undefined nibbles encode to 00.
- `start` is ignored while `busy`=1. There is no queuing.
- `value` is sampled only on the accepting edge. Later changes do not affect the conversion in flight.
- `both7seg` and `overflow` hold their values between conversions. All 14 bits change on a single edge, so the downstream multiplexer never sees a mixed word.
- Reset:
  - `rst`=0 forces IDLE immediately.
  - Outputs go to `both7seg`=0 (blank), `busy`=0, `done`=0, `overflow`=0.
  - Internal counter and registers are cleared.
- Reset mid-conversion aborts the conversion. No `done` is produced, and the output stays blank until the next completed conversion.

## Timing
- `start` accepted at edge k: `busy`=1 after edge k.
- Shifts happen on edges k+1..k+8. Edge k+8 enters ENC.
- Edge k+9: `both7seg`, `overflow` and `done`=1 are visible, and `busy`=0.
- After edge k+10: `done`=0.
- Latency is 9 cycles from the accepting edge to the result.
- Maximum throughput is one conversion per 10 cycles. A `start` held high across edge k+10 begins the next conversion at k+10.
- `done` and `busy` are never high in the same cycle.
- Reset is asynchronous on assertion; there are no output glitches beyond the reset values. Deassertion is assumed synchronous to `clk` by the system reset tree.

## Test plan
- Reset, then `value`=42 with `start` at edge k:
  - `busy` high during k..k+8.
  - At edge k+9: `both7seg`=14'b1100110_1011011 ({66,5B}), `overflow`=0, `done` pulses 1 cycle.
- `LZB`=1:
  - `value`=7 gives {00,07}.
  - `value`=0 gives {00,3F}.
  - With `LZB`=0, `value`=7 gives {3F,07}.
- Boundaries:
  - `value`=99 gives {6F,6F}, `overflow`=0.
  - `value`=100 gives {40,40}, `overflow`=1.
  - `value`=255 gives {40,40}, `overflow`=1.
- Start during busy:
  - Start 42 at k; pulse `start` with `value`=13 at k+4.
  - Result is still 42 at k+9. No second `done`, and `busy` stays low after k+9.
- Reset mid-conversion:
  - Start 55; drop `rst` at k+5.
  - Outputs are 0 at once and no `done` occurs.
  - After release, start 55: result {6D,6D} 9 cycles later.
- Back-to-back with `start` held high and `value` 12 then 34:
  - `done` at k+9 and k+19.
  - Results {06,5B} then {4F,66}, each output word changing on a single edge.

Source files
------------

// File: rtl/bin2seg_encoder_if.sv
// Handshake and result bundle between a requester and the binary-to-seven-segment encoder.
interface bin2seg_encoder_if;
    logic        start;
    logic [7:0]  value;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [13:0] both7seg;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  overflow,
        input  both7seg
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output overflow,
        output both7seg
    );
endinterface

// File: rtl/bin2seg_encoder.sv
// Bit-serial double-dabble conversion of an 8-bit value into a packed two-digit
// seven-segment word; out-of-range values (>99) are shown as two dashes.
module bin2seg_encoder #(
    parameter bit LZB = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bin2seg_encoder_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, CONV, ENC} state_t;

    state_t      r_state;
    logic [7:0]  r_bin;
    logic [11:0] r_bcd;
    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic        r_overflow;
    logic [13:0] r_seg;

    logic [10:0] w_adj;
    logic        w_ovf;
    logic [6:0]  w_tensSeg;
    logic [6:0]  w_unitsSeg;

    function automatic logic [6:0] segCode(input logic [3:0] d);
        case (d)
            4'd0:    segCode = 7'h3F;
            4'd1:    segCode = 7'h06;
            4'd2:    segCode = 7'h5B;
            4'd3:    segCode = 7'h4F;
            4'd4:    segCode = 7'h66;
            4'd5:    segCode = 7'h6D;
            4'd6:    segCode = 7'h7D;
            4'd7:    segCode = 7'h07;
            4'd8:    segCode = 7'h7F;
            4'd9:    segCode = 7'h6F;
            default: segCode = 7'h00;
        endcase
    endfunction

    function automatic logic [3:0] dabble(input logic [3:0] n);
        dabble = (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // Hundreds never reaches 5 for an 8-bit input, so only its low 3 bits feed the shift.
    always_comb begin
        w_adj = {r_bcd[10:8], dabble(r_bcd[7:4]), dabble(r_bcd[3:0])};
    end

    always_comb begin
        w_ovf      = (r_bcd[11:8] != 4'd0) || (r_bcd[7:4] > 4'd9);
        w_unitsSeg = segCode(r_bcd[3:0]);
        w_tensSeg  = (LZB && r_bcd[7:4] == 4'd0) ? 7'h00 : segCode(r_bcd[7:4]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_seg      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_bin   <= bus.value;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= {w_adj, r_bin[7]};
                    r_bin <= {r_bin[6:0], 1'b0};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= ENC;
                    end
                end
                ENC: begin
                    // Whole word, flag and pulse land on one edge so the display never sees a mix.
                    r_overflow <= w_ovf;
                    r_seg      <= w_ovf ? {7'h40, 7'h40} : {w_tensSeg, w_unitsSeg};
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.overflow = r_overflow;
    assign bus.both7seg = r_seg;

endmodule

// File: tb/tb_bin2seg_encoder.sv
// Scoreboard bench for bin2seg_encoder: directed vectors, one instance with and one without
// leading-zero blanking, checked by a done-driven monitor.
module tb_bin2seg_encoder;

    typedef struct {
        logic [13:0] seg;
        logic [13:0] seg0;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cycle;
    exp_t sbQ[$];
    logic [13:0] lastSeg;
    logic [13:0] lastSeg0;

    bin2seg_encoder_if ifc ();
    bin2seg_encoder_if if0 ();

    assign if0.start = ifc.start;
    assign if0.value = ifc.value;

    bin2seg_encoder #(.LZB(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    bin2seg_encoder #(.LZB(1'b0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    initial begin
        #500000;
        $display("[TB] FAIL timeout actual=running required=finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total = total + 1;
        if (act !== req) begin
            bad = bad + 1;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per done pulse; between pulses the words must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            lastSeg  = '0;
            lastSeg0 = '0;
        end else begin
            checkOutput("done_busy_exclusive", {31'd0, ifc.done & ifc.busy}, 32'd0);
            if (ifc.done) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("seg_lzb1", {18'd0, ifc.both7seg}, {18'd0, e.seg});
                    checkOutput("seg_lzb0", {18'd0, if0.both7seg}, {18'd0, e.seg0});
                    checkOutput("overflow", {31'd0, ifc.overflow}, {31'd0, e.ovf});
                    checkOutput("done_cycle", cycle, e.cyc);
                    checkOutput("done_lzb0", {31'd0, if0.done}, 32'd1);
                    lastSeg  = e.seg;
                    lastSeg0 = e.seg0;
                end
            end else begin
                checkOutput("seg_hold", {18'd0, ifc.both7seg}, {18'd0, lastSeg});
                checkOutput("seg0_hold", {18'd0, if0.both7seg}, {18'd0, lastSeg0});
            end
        end
    end

    // One conversion; optionally pulses start with another value at edge k+injectEdge.
    task automatic applyStimulus(input logic [7:0] val, input logic [13:0] expSeg,
                                 input logic [13:0] expSeg0, input logic expOvf,
                                 input int injectEdge, input logic [7:0] injectVal);
        exp_t e;
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.value = val;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        e.seg  = expSeg;
        e.seg0 = expSeg0;
        e.ovf  = expOvf;
        e.cyc  = cycle + 9;
        sbQ.push_back(e);
        checkOutput("busy_at_k", {31'd0, ifc.busy}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            if (i == injectEdge) begin
                ifc.start = 1'b1;
                ifc.value = injectVal;
            end
            @(posedge clk);
            #1;
            ifc.start = 1'b0;
            checkOutput("busy_during_conv", {31'd0, ifc.busy}, 32'd1);
        end
        @(posedge clk);
        #1;
        checkOutput("busy_after_k9", {31'd0, ifc.busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_dropped_k10", {31'd0, ifc.done}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   acc;
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        ifc.value = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_seg", {18'd0, ifc.both7seg}, 32'd0);
        checkOutput("reset_busy", {31'd0, ifc.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, ifc.done}, 32'd0);
        checkOutput("reset_ovf", {31'd0, ifc.overflow}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        applyStimulus(8'd42,  {7'h66, 7'h5B}, {7'h66, 7'h5B}, 1'b0, 0, 8'd0);
        applyStimulus(8'd7,   {7'h00, 7'h07}, {7'h3F, 7'h07}, 1'b0, 0, 8'd0);
        applyStimulus(8'd0,   {7'h00, 7'h3F}, {7'h3F, 7'h3F}, 1'b0, 0, 8'd0);
        applyStimulus(8'd99,  {7'h6F, 7'h6F}, {7'h6F, 7'h6F}, 1'b0, 0, 8'd0);
        applyStimulus(8'd100, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b1, 0, 8'd0);
        applyStimulus(8'd255, {7'h40, 7'h40}, {7'h40, 7'h40}, 1'b1, 0, 8'd0);
        applyStimulus(8'd42,  {7'h66, 7'h5B}, {7'h66, 7'h5B}, 1'b0, 4, 8'd13);
        @(posedge clk);
        #1;
        checkOutput("busy_low_after_ignored_start", {31'd0, ifc.busy}, 32'd0);

        // Reset in the middle of a conversion of 55.
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.value = 8'd55;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_seg", {18'd0, ifc.both7seg}, 32'd0);
        checkOutput("midreset_busy", {31'd0, ifc.busy}, 32'd0);
        checkOutput("midreset_done", {31'd0, ifc.done}, 32'd0);
        checkOutput("midreset_ovf", {31'd0, ifc.overflow}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        applyStimulus(8'd55, {7'h6D, 7'h6D}, {7'h6D, 7'h6D}, 1'b0, 0, 8'd0);

        // Back-to-back with start held high: 12 then 34.
        @(negedge clk);
        ifc.start = 1'b1;
        ifc.value = 8'd12;
        @(posedge clk);
        #1;
        acc       = cycle;
        ifc.value = 8'd34;
        e.seg  = {7'h06, 7'h5B};
        e.seg0 = {7'h06, 7'h5B};
        e.ovf  = 1'b0;
        e.cyc  = acc + 9;
        sbQ.push_back(e);
        e.seg  = {7'h4F, 7'h66};
        e.seg0 = {7'h4F, 7'h66};
        e.cyc  = acc + 19;
        sbQ.push_back(e);
        repeat (10) @(posedge clk);
        #1;
        ifc.start = 1'b0;
        checkOutput("b2b_second_accepted", {31'd0, ifc.busy}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("b2b_busy_after", {31'd0, ifc.busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", sbQ.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
